// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath width, instruction step and the
// fetch FSM encoding. Optional macro IFETCH_MISALIGN_CHECK_EN adds the FAULT
// state used for misaligned redirect targets.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Sequential fetch advances by one 32-bit instruction.
  localparam logic [XLEN-1:0] InstrStep = 32'd4;

  // Clears the byte-offset bits of an address.
  localparam logic [XLEN-1:0] WordAlignMask = 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    StFetch    = 2'd0,
    StWaitData = 2'd1,
    StValid    = 2'd2,
    StFault    = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    StFetch    = 2'd0,
    StWaitData = 2'd1,
    StValid    = 2'd2
  } fetch_state_e;
`endif

endpackage

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit. Issues one read strobe, captures
// the word returned the following cycle and holds it on a valid/ready
// handshake. Redirects restart fetch at a new PC and drop any word in flight.
// Optional macro IFETCH_MISALIGN_CHECK_EN: misaligned redirects park the unit
// in a FAULT state (fetch_fault=1) instead of silently aligning the target.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic [XLEN-1:0] memory_address,
  output logic            memory_read_strobe,
  input  logic [XLEN-1:0] memory_read_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_data_q, instr_data_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = redirect_pc & WordAlignMask;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic redirect_misaligned;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`endif

  // Next-state logic: sequential fetch progress, then redirect override.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_data_d = instr_data_q;
    instr_pc_d   = instr_pc_q;

    unique case (state_q)
      StFetch: begin
        state_d = StWaitData;
      end
      StWaitData: begin
        instr_data_d = memory_read_data;
        instr_pc_d   = pc_q;
        state_d      = StValid;
      end
      StValid: begin
        if (instr_ready) begin
          pc_d    = pc_q + InstrStep;
          state_d = StFetch;
        end
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      StFault: begin
        state_d = StFault;
      end
`endif
      default: begin
        state_d = StFetch;
      end
    endcase

    // A redirect wins over a same-cycle accept and discards any word
    // arriving this cycle, so the output registers keep their old contents.
    if (redirect_valid) begin
      instr_data_d = instr_data_q;
      instr_pc_d   = instr_pc_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (redirect_misaligned) begin
        pc_d    = pc_q;
        state_d = StFault;
      end else begin
        pc_d    = redirect_target;
        state_d = StFetch;
      end
`else
      pc_d    = redirect_target;
      state_d = StFetch;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_data_q <= instr_data_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  // Outputs decoded from the current state; the strobe is held off while
  // reset is asserted so the first request follows reset release.
  always_comb begin
    memory_address     = pc_q;
    memory_read_strobe = (state_q == StFetch) && !RESET;
    instr_valid        = (state_q == StValid);
    instr_data         = instr_data_q;
    instr_pc           = instr_pc_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
    fetch_fault        = (state_q == StFault);
`endif
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a transaction-level
// model. Honors IFETCH_MISALIGN_CHECK_EN when defined.
module tb_instruction_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        CLK;
  logic        RESET;
  logic [31:0] memory_address;
  logic        memory_read_strobe;
  logic [31:0] memory_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  instruction_fetch #(
    .RESET_PC(ResetPc)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .memory_address    (memory_address),
    .memory_read_strobe(memory_read_strobe),
    .memory_read_data  (memory_read_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_data        (instr_data),
    .instr_pc          (instr_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault       (fetch_fault)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory contents: distinct word for every address (odd multiplier).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: data valid the cycle after the strobe, junk otherwise.
  always @(posedge CLK) begin
    memory_read_data <= memory_read_strobe ? mem_word(memory_address) : 32'hDEAD_BEEF;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next fetch address, cycles elapsed since the fetch
  // request started, and the last instruction delivered.
  logic [31:0] m_pc, m_data, m_ipc;
  int          m_age;
  bit          m_fault;

  task automatic model_step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    if (rst) begin
      m_pc = ResetPc; m_age = 0; m_fault = 0; m_data = 0; m_ipc = 0;
    end else if (rv) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) m_fault = 1;
      else begin m_fault = 0; m_pc = rpc; m_age = 0; end
`else
      m_pc = rpc - (rpc % 4); m_age = 0;
`endif
    end else if (!m_fault) begin
      if (m_age == 1) begin m_data = mem_word(m_pc); m_ipc = m_pc; end
      if (m_age >= 2 && rdy) begin m_pc = m_pc + 4; m_age = 0; end
      else if (m_age < 2) m_age++;
    end
  endtask

  // Observed outputs of the most recent cycle.
  logic        o_strobe, o_valid, o_fault;
  logic [31:0] o_addr, o_data, o_ipc;

  // One clock cycle: apply inputs, compare mid-cycle against the model,
  // then advance the model at the rising edge.
  task automatic drive(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit exp_strobe, exp_valid;
    RESET = rst; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    @(negedge CLK);
    exp_strobe = !rst && !m_fault && (m_age == 0);
    exp_valid  = !m_fault && (m_age >= 2);
    o_strobe = memory_read_strobe; o_valid = instr_valid;
    o_addr = memory_address; o_data = instr_data; o_ipc = instr_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    o_fault = fetch_fault;
    chk("model_fault", {31'd0, o_fault}, {31'd0, m_fault});
`else
    o_fault = 1'b0;
`endif
    chk("model_strobe", {31'd0, o_strobe}, {31'd0, exp_strobe});
    chk("model_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    if (exp_strobe) chk("model_addr", o_addr, m_pc);
    if (exp_valid) begin
      chk("model_data", o_data, m_data);
      chk("model_ipc", o_ipc, m_ipc);
    end
    @(posedge CLK);
    model_step(rst, rv, rpc, rdy);
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_strobe;
    bit          e_valid;
    logic [31:0] e_addr;
    bit          chk_d;
    logic [31:0] e_ipc;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit rv, input logic [31:0] rpc,
                              input bit rdy, input bit es, input bit ev,
                              input logic [31:0] ea, input bit cd,
                              input logic [31:0] eipc, input logic [31:0] edata);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_strobe = es; v.e_valid = ev;
    v.e_addr = ea; v.chk_d = cd; v.e_ipc = eipc; v.e_data = edata;
    vecs.push_back(v);
  endfunction

  initial begin
    RESET = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge CLK);
    model_step(1'b1, 1'b0, 32'd0, 1'b0);
    #1;

    // Outputs expected during each cycle: rst rv rpc rdy | strobe valid addr | chk ipc data
    add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);                                  // reset held
    add(0, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0);                              // first strobe @0
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 1, 32'h0, mem_word(32'h0));
    add(0, 0, 0, 1, 1, 0, 32'h4, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 1, 32'h4, mem_word(32'h4));
    add(0, 0, 0, 1, 1, 0, 32'h8, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)                                         // consumer stalls
      add(0, 0, 0, 0, 0, 1, 0, 1, 32'h8, mem_word(32'h8));
    add(0, 0, 0, 1, 0, 1, 0, 1, 32'h8, mem_word(32'h8));
    add(0, 0, 0, 1, 1, 0, 32'hC, 0, 0, 0);
    add(0, 1, 32'h40, 1, 0, 0, 0, 0, 0, 0);                             // redirect in WAIT
    add(0, 0, 0, 1, 1, 0, 32'h40, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h80, 1, 0, 1, 0, 1, 32'h40, mem_word(32'h40));         // redirect beats ready
    add(0, 0, 0, 1, 1, 0, 32'h80, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, 1, 32'h80, mem_word(32'h80));
    add(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFC, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    add(0, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0);                              // PC wrapped
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 1, 32'h0, mem_word(32'h0));                // reset in VALID
    add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, ResetPc, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      chk($sformatf("tbl%0d_strobe", i), {31'd0, o_strobe}, {31'd0, vecs[i].e_strobe});
      chk($sformatf("tbl%0d_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_strobe) chk($sformatf("tbl%0d_addr", i), o_addr, vecs[i].e_addr);
      if (vecs[i].chk_d) begin
        chk($sformatf("tbl%0d_ipc", i), o_ipc, vecs[i].e_ipc);
        chk($sformatf("tbl%0d_data", i), o_data, vecs[i].e_data);
      end
    end

    // Misaligned redirect handling.
`ifdef IFETCH_MISALIGN_CHECK_EN
    drive(0, 1, 32'h42, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      chk("fault_set", {31'd0, o_fault}, 32'd1);
      chk("fault_nostrobe", {31'd0, o_strobe}, 32'd0);
    end
    drive(0, 1, 32'h43, 0);
    drive(0, 0, 0, 0);
    chk("fault_kept", {31'd0, o_fault}, 32'd1);
    chk("fault_kept_nostrobe", {31'd0, o_strobe}, 32'd0);
    drive(0, 1, 32'h44, 0);
    drive(0, 0, 0, 0);
    chk("fault_clear", {31'd0, o_fault}, 32'd0);
    chk("fault_clear_strobe", {31'd0, o_strobe}, 32'd1);
    chk("fault_clear_addr", o_addr, 32'h44);
`else
    drive(0, 1, 32'h42, 0);
    drive(0, 0, 0, 0);
    chk("align_strobe", {31'd0, o_strobe}, 32'd1);
    chk("align_addr", o_addr, 32'h40);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_rv, r_rdy;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 63) == 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      r_rdy = ($urandom_range(0, 1) == 1);
      r_pc  = $urandom();
      if ($urandom_range(0, 3) != 0) r_pc = r_pc & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      drive(r_rst, r_rv, r_pc, r_rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
